// File: rtl/row_feeder.sv
// row_feeder: write-side sequencer for the integral-image row chain.
// Takes a raster pixel stream (valid/ready), clears the row integrals at
// frame start, and drives registered write enable/data/coordinates with
// a one-cycle latency from accept to write.
module row_feeder #(
  parameter int DATA_WIDTH   = 8,
  parameter int CNT_WIDTH    = 10,
  parameter int FRAME_WIDTH  = 320,
  parameter int FRAME_HEIGHT = 240,
  parameter int WINDOW_SIZE  = 24,
  parameter int IWIDTH       = 3
) (
  input  logic                  clk_os,
  input  logic                  reset_os,
  input  logic                  i_sof,
  input  logic [DATA_WIDTH-1:0] i_pixel,
  input  logic                  i_pixel_valid,
  output logic                  o_pixel_ready,
  input  logic                  i_hold,
  output logic                  o_wen,
  output logic [DATA_WIDTH-1:0] o_fifo_in,
  output logic                  o_row_clear,
  output logic [CNT_WIDTH-1:0]  o_col,
  output logic [CNT_WIDTH-1:0]  o_row,
  output logic                  o_window_valid,
  output logic                  o_frame_done
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CLEAR  = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam int CLR_W = (IWIDTH > 1) ? $clog2(IWIDTH) : 1;
  localparam logic [CLR_W-1:0]     CLR_LAST = CLR_W'(IWIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] COL_LAST = CNT_WIDTH'(FRAME_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] ROW_LAST = CNT_WIDTH'(FRAME_HEIGHT - 1);
  localparam logic [CNT_WIDTH-1:0] WIN_M1   = CNT_WIDTH'(WINDOW_SIZE - 1);

  logic [1:0]           state;
  logic [CLR_W-1:0]     clr_cnt;
  logic [CNT_WIDTH-1:0] col_cnt;   // coordinates of the next pixel to accept
  logic [CNT_WIDTH-1:0] row_cnt;
  logic                 accept;

  // Ready only while streaming; an sof in the same cycle wins over the pixel.
  assign o_pixel_ready = (state == S_STREAM) & ~i_hold & ~i_sof;
  assign accept        = i_pixel_valid & o_pixel_ready;

  // FSM, coordinate counters and the registered write-side outputs.
  always_ff @(posedge clk_os or negedge reset_os) begin
    if (!reset_os) begin
      state          <= S_IDLE;
      clr_cnt        <= '0;
      col_cnt        <= '0;
      row_cnt        <= '0;
      o_wen          <= 1'b0;
      o_fifo_in      <= '0;
      o_row_clear    <= 1'b0;
      o_col          <= '0;
      o_row          <= '0;
      o_window_valid <= 1'b0;
      o_frame_done   <= 1'b0;
    end else begin
      // Strobes default low; only a write cycle raises them.
      o_wen          <= 1'b0;
      o_row_clear    <= 1'b0;
      o_window_valid <= 1'b0;
      o_frame_done   <= 1'b0;
      if (i_sof) begin
        // Frame start (or abort): begin the clear burst, drop any partial frame.
        state       <= S_CLEAR;
        clr_cnt     <= '0;
        col_cnt     <= '0;
        row_cnt     <= '0;
        o_wen       <= 1'b1;
        o_row_clear <= 1'b1;
        o_fifo_in   <= '0;
        o_col       <= '0;
        o_row       <= '0;
      end else begin
        case (state)
          S_CLEAR: begin
            if (clr_cnt == CLR_LAST) begin
              state <= S_STREAM;
            end else begin
              clr_cnt     <= clr_cnt + 1'b1;
              o_wen       <= 1'b1;
              o_row_clear <= 1'b1;
              o_fifo_in   <= '0;
            end
          end
          S_STREAM: begin
            if (accept) begin
              o_wen          <= 1'b1;
              o_fifo_in      <= i_pixel;
              o_col          <= col_cnt;
              o_row          <= row_cnt;
              o_window_valid <= (col_cnt >= WIN_M1) && (row_cnt >= WIN_M1);
              if (col_cnt == COL_LAST) begin
                col_cnt <= '0;
                if (row_cnt == ROW_LAST) begin
                  row_cnt      <= '0;
                  state        <= S_DONE;
                  o_frame_done <= 1'b1;
                end else begin
                  row_cnt <= row_cnt + 1'b1;
                end
              end else begin
                col_cnt <= col_cnt + 1'b1;
              end
            end
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_row_feeder.sv
// Directed bench for row_feeder: a per-cycle vector table for the clear /
// handshake corner cases, then hand sequences for abort, full frame with
// a mid-line stall, and asynchronous reset. A negedge monitor models the
// expected raster order and window/done flags for every write.
module tb_row_feeder;

  logic       clk_os = 1'b0;
  logic       reset_os;
  logic       i_sof;
  logic [7:0] i_pixel;
  logic       i_pixel_valid;
  logic       o_pixel_ready;
  logic       i_hold;
  logic       o_wen;
  logic [7:0] o_fifo_in;
  logic       o_row_clear;
  logic [9:0] o_col;
  logic [9:0] o_row;
  logic       o_window_valid;
  logic       o_frame_done;

  row_feeder dut (
    .clk_os(clk_os), .reset_os(reset_os), .i_sof(i_sof), .i_pixel(i_pixel),
    .i_pixel_valid(i_pixel_valid), .o_pixel_ready(o_pixel_ready), .i_hold(i_hold),
    .o_wen(o_wen), .o_fifo_in(o_fifo_in), .o_row_clear(o_row_clear), .o_col(o_col),
    .o_row(o_row), .o_window_valid(o_window_valid), .o_frame_done(o_frame_done)
  );

  always #5 clk_os = ~clk_os;

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: expected raster position of the next write, reset by a clear write.
  int m_col = 0, m_row = 0;
  int m_err = 0, wen_cnt = 0, win_cnt = 0, done_cnt = 0;
  always @(negedge clk_os) begin
    if (o_wen && o_row_clear) begin
      m_col = 0;
      m_row = 0;
      if (o_fifo_in != 8'd0 || o_window_valid || o_frame_done) m_err++;
    end else if (o_wen) begin
      if (o_col != 10'(m_col) || o_row != 10'(m_row) || o_fifo_in != 8'(m_col)) m_err++;
      if (o_window_valid != (m_col >= 23 && m_row >= 23)) m_err++;
      if (o_frame_done != (m_col == 319 && m_row == 239)) m_err++;
      wen_cnt++;
      if (o_window_valid) win_cnt++;
      if (o_frame_done) done_cnt++;
      if (m_col == 319) begin
        m_col = 0;
        m_row = (m_row == 239) ? 0 : m_row + 1;
      end else begin
        m_col++;
      end
    end else if (o_window_valid || o_frame_done) begin
      m_err++;
    end
  end

  // Driver position: pixel value presented is always the column's low byte.
  int drv_col = 0, drv_row = 0;

  task automatic feed(input int n);
    int got = 0;
    int cyc = 0;
    logic rdy;
    while (got < n && cyc < n + 50) begin
      i_pixel_valid = 1'b1;
      i_pixel = 8'(drv_col);
      #1 rdy = o_pixel_ready;
      @(posedge clk_os); #1;
      cyc++;
      if (rdy) begin
        got++;
        if (drv_col == 319) begin
          drv_col = 0;
          drv_row = (drv_row == 239) ? 0 : drv_row + 1;
        end else drv_col++;
      end
    end
    chk("feed_accepts", got, n);
  endtask

  typedef struct {
    logic sof, valid, hold;
    logic [7:0] pix;
    logic ready, wen, clr;
    logic [7:0] fifo;
    logic [9:0] col;
  } vec_t;

  vec_t tbl[12];
  int s_wen, s_win, s_done;

  initial begin
    //              sof valid hold pix    | ready wen clr fifo col
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'd0, 10'd0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'd0, 10'd0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'd0, 10'd0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0, 10'd0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 8'd0,  1'b1, 1'b1, 1'b0, 8'd0, 10'd0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 8'd0, 10'd0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 8'h66, 1'b1, 1'b0, 1'b0, 8'd0, 10'd0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 8'd1,  1'b1, 1'b1, 1'b0, 8'd1, 10'd1};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 8'h77, 1'b0, 1'b1, 1'b1, 8'd0, 10'd0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'd0, 10'd0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'd0, 10'd0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0, 10'd0};

    reset_os = 1'b0; i_sof = 1'b0; i_pixel = '0; i_pixel_valid = 1'b0; i_hold = 1'b0;
    repeat (3) @(posedge clk_os);
    #1;
    chk("rst_wen", int'(o_wen), 0);
    chk("rst_ready", int'(o_pixel_ready), 0);
    chk("rst_outs", int'({o_fifo_in, o_row_clear, o_col, o_row, o_window_valid, o_frame_done}), 0);
    #2 reset_os = 1'b1;
    @(posedge clk_os); #1;
    chk("idle_ready", int'(o_pixel_ready), 0);
    chk("idle_wen", int'(o_wen), 0);

    // Clear burst, first writes, hold, and an sof with a pixel pending.
    for (int i = 0; i < 12; i++) begin
      i_sof = tbl[i].sof; i_pixel_valid = tbl[i].valid; i_hold = tbl[i].hold; i_pixel = tbl[i].pix;
      #1 chk($sformatf("tbl[%0d].ready", i), int'(o_pixel_ready), int'(tbl[i].ready));
      @(posedge clk_os); #1;
      chk($sformatf("tbl[%0d].wen", i), int'(o_wen), int'(tbl[i].wen));
      chk($sformatf("tbl[%0d].clr", i), int'(o_row_clear), int'(tbl[i].clr));
      chk($sformatf("tbl[%0d].fifo", i), int'(o_fifo_in), int'(tbl[i].fifo));
      chk($sformatf("tbl[%0d].col", i), int'(o_col), int'(tbl[i].col));
    end
    i_sof = 1'b0; i_hold = 1'b0;

    // Abort at (10,50): pixel not taken, 3-cycle clear, no frame_done.
    s_done = done_cnt;
    drv_col = 0; drv_row = 0;
    feed(50 * 320 + 10);
    chk("abort_pos_row", o_row == 10'd50 && o_col == 10'd9 ? 1 : 0, 1);
    i_sof = 1'b1; i_pixel_valid = 1'b1; i_pixel = 8'd10;
    #1 chk("abort_ready", int'(o_pixel_ready), 0);
    @(posedge clk_os); #1;
    i_sof = 1'b0; i_pixel_valid = 1'b0;
    chk("abort_clr0", int'({o_wen, o_row_clear}), 3);
    chk("abort_fifo0", int'(o_fifo_in), 0);
    chk("abort_coord", int'({o_col, o_row}), 0);
    @(posedge clk_os); #1 chk("abort_clr1", int'({o_wen, o_row_clear}), 3);
    @(posedge clk_os); #1 chk("abort_clr2", int'({o_wen, o_row_clear}), 3);
    @(posedge clk_os); #1 chk("abort_clr_end", int'({o_wen, o_row_clear}), 0);
    chk("abort_no_done", done_cnt - s_done, 0);

    // Full frame with a 5-cycle stall after the col 100 write on line 0.
    s_wen = wen_cnt; s_win = win_cnt; s_done = done_cnt;
    drv_col = 0; drv_row = 0;
    feed(101);
    chk("pre_hold_col", int'(o_col), 100);
    i_hold = 1'b1; i_pixel_valid = 1'b1; i_pixel = 8'd101;
    for (int k = 0; k < 5; k++) begin
      #1 chk($sformatf("hold%0d_ready", k), int'(o_pixel_ready), 0);
      @(posedge clk_os); #1 chk($sformatf("hold%0d_wen", k), int'(o_wen), 0);
    end
    i_hold = 1'b0;
    feed(1);
    chk("post_hold_col", int'(o_col), 101);
    chk("post_hold_fifo", int'(o_fifo_in), 101);
    feed(76800 - 102);
    chk("last_done", int'(o_frame_done), 1);
    chk("last_wen", int'(o_wen), 1);
    chk("last_coord", int'({o_col, o_row}), (319 << 10) | 239);
    chk("last_window", int'(o_window_valid), 1);
    i_pixel_valid = 1'b0;
    @(posedge clk_os); #1;
    chk("after_done", int'({o_frame_done, o_wen}), 0);
    chk("after_ready", int'(o_pixel_ready), 0);
    chk("frame_writes", wen_cnt - s_wen, 76800);
    chk("frame_windows", win_cnt - s_win, 297 * 217);
    chk("frame_done_pulses", done_cnt - s_done, 1);
    chk("order_errors", m_err, 0);

    // Asynchronous reset in the middle of streaming.
    i_sof = 1'b1;
    @(posedge clk_os); #1 i_sof = 1'b0;
    repeat (3) @(posedge clk_os);
    #1;
    drv_col = 0; drv_row = 0;
    feed(30);
    chk("pre_rst_wen", int'(o_wen), 1);
    #1 reset_os = 1'b0;
    #1;
    chk("arst_ready", int'(o_pixel_ready), 0);
    chk("arst_outs", int'({o_wen, o_fifo_in, o_row_clear, o_col, o_row, o_window_valid, o_frame_done}), 0);
    #1 reset_os = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk_os); #1;
      chk($sformatf("post_rst%0d", k), int'({o_wen, o_pixel_ready}), 0);
    end
    chk("order_errors_end", m_err, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
